// File: rtl/uart_framed_echo.sv
// uart_framed_echo: parses HEADER/LEN/PAYLOAD frames from a byte-stream
// receiver, buffers the (masked) payload in a FIFO and echoes it back
// through a byte-oriented UART transmitter handshake.
module uart_framed_echo #(
    parameter logic [7:0] HEADER_BYTE    = 8'hAA,
    parameter int         FIFO_DEPTH     = 16,
    parameter int         MAX_LEN        = 64,
    parameter int         TIMEOUT_CYCLES = 250_000,
    parameter logic [7:0] XOR_MASK       = 8'h00
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_rx_dv,
    input  logic [7:0]                    i_rx_byte,
    input  logic                          i_tx_active,
    input  logic                          i_tx_done,
    output logic                          o_tx_dv,
    output logic [7:0]                    o_tx_byte,
    output logic                          o_in_frame,
    output logic                          o_frame_done,
    output logic                          o_frame_err,
    output logic [7:0]                    o_overflow_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    LEN_MAX    = 8'(MAX_LEN);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        WAIT_HEADER,
        WAIT_LEN,
        PAYLOAD
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    remaining, remaining_nxt;
    logic [IW-1:0] idle_cnt, idle_nxt;
    logic          done_nxt, err_nxt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          tx_busy;
    logic          push_req, push_ok, pop;

    // Frame FSM state register plus its counters and the one-cycle status pulses.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (i_rst) begin
            state        <= WAIT_HEADER;
            remaining    <= '0;
            idle_cnt     <= '0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            remaining    <= remaining_nxt;
            idle_cnt     <= idle_nxt;
            o_frame_done <= done_nxt;
            o_frame_err  <= err_nxt;
        end
    end

    // Next-state logic: header hunt, length validation, payload counting, idle timeout.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nxt     = state;
        remaining_nxt = remaining;
        idle_nxt      = idle_cnt;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        case (state)
            WAIT_HEADER: begin
                idle_nxt = '0;
                if (i_rx_dv && (i_rx_byte == HEADER_BYTE)) begin
                    state_nxt = WAIT_LEN;
                end
            end
            WAIT_LEN: begin
                if (i_rx_dv) begin
                    idle_nxt = '0;
                    if (i_rx_byte == 8'h00) begin
                        state_nxt = WAIT_HEADER;
                    end else if (i_rx_byte > LEN_MAX) begin
                        state_nxt = WAIT_HEADER;
                        err_nxt   = 1'b1;
                    end else begin
                        remaining_nxt = i_rx_byte;
                        state_nxt     = PAYLOAD;
                    end
                end else if (idle_cnt == IDLE_LAST) begin
                    idle_nxt  = '0;
                    state_nxt = WAIT_HEADER;
                    err_nxt   = 1'b1;
                end else begin
                    idle_nxt = idle_cnt + 1'b1;
                end
            end
            PAYLOAD: begin
                if (i_rx_dv) begin
                    idle_nxt      = '0;
                    remaining_nxt = remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        state_nxt = WAIT_HEADER;
                        done_nxt  = 1'b1;
                    end
                end else if (idle_cnt == IDLE_LAST) begin
                    idle_nxt      = '0;
                    remaining_nxt = '0;
                    state_nxt     = WAIT_HEADER;
                    err_nxt       = 1'b1;
                end else begin
                    idle_nxt = idle_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_HEADER;
            end
        endcase
    end

    assign o_in_frame   = (state != WAIT_HEADER);
    assign o_fifo_level = level;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push_req = (state == PAYLOAD) && i_rx_dv;
    assign pop      = (level != '0) && !tx_busy && !i_tx_active;
    assign push_ok  = push_req && ((level != FULL_LEVEL) || pop);

    // FIFO storage write port.
    always_ff @(posedge i_clk) begin
        // NOTE: the storage array has no reset; the pointers and level define
        // which entries are valid, so stale contents are never observed.
        if (push_ok) begin
            mem[wr_ptr] <= i_rx_byte ^ XOR_MASK;
        end
    end

    // FIFO pointers/level, transmit handshake and overflow accounting.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            tx_busy        <= 1'b0;
            o_tx_dv        <= 1'b0;
            o_tx_byte      <= 8'h00;
            o_overflow_cnt <= 8'h00;
        end else begin
            o_tx_dv <= pop;
            if (pop) begin
                o_tx_byte <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
                tx_busy   <= 1'b1;
            end else if (i_tx_done) begin
                tx_busy <= 1'b0;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push_req && !push_ok && (o_overflow_cnt != 8'hFF)) begin
                o_overflow_cnt <= o_overflow_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_framed_echo.sv
// tb_uart_framed_echo: directed test of uart_framed_echo. Two instances share
// the receive stimulus and differ only in XOR_MASK (8'h00 and 8'h20); each has
// its own small transmitter model that answers o_tx_dv with i_tx_done.
module tb_uart_framed_echo;

    localparam logic [7:0] MASK_B = 8'h20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_active = 1'b0;

    logic       a_tx_done = 1'b0;
    logic       a_tx_dv, a_in_frame, a_done, a_err;
    logic [7:0] a_tx_byte, a_ovf;
    logic [2:0] a_level;

    logic       b_tx_done = 1'b0;
    logic       b_tx_dv, b_in_frame, b_done, b_err;
    logic [7:0] b_tx_byte, b_ovf;
    logic [2:0] b_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_framed_echo #(
        .HEADER_BYTE(8'hAA), .FIFO_DEPTH(4), .MAX_LEN(64),
        .TIMEOUT_CYCLES(40), .XOR_MASK(8'h00)
    ) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
        .i_tx_active(tx_active), .i_tx_done(a_tx_done),
        .o_tx_dv(a_tx_dv), .o_tx_byte(a_tx_byte), .o_in_frame(a_in_frame),
        .o_frame_done(a_done), .o_frame_err(a_err),
        .o_overflow_cnt(a_ovf), .o_fifo_level(a_level)
    );

    uart_framed_echo #(
        .HEADER_BYTE(8'hAA), .FIFO_DEPTH(4), .MAX_LEN(64),
        .TIMEOUT_CYCLES(40), .XOR_MASK(MASK_B)
    ) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
        .i_tx_active(tx_active), .i_tx_done(b_tx_done),
        .o_tx_dv(b_tx_dv), .o_tx_byte(b_tx_byte), .o_in_frame(b_in_frame),
        .o_frame_done(b_done), .o_frame_err(b_err),
        .o_overflow_cnt(b_ovf), .o_fifo_level(b_level)
    );

    // Transmit logs and pulse counters, written only by the monitors below.
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int done_a = 0, err_a = 0, busy_a = 0;
    int done_b = 0, err_b = 0, busy_b = 0;

    // Transmitter model A: logs each request, reports done three cycles later.
    always @(negedge clk) begin
        a_tx_done = 1'b0;
        if (busy_a > 0) begin
            busy_a--;
            if (busy_a == 0) a_tx_done = 1'b1;
        end
        if (a_tx_dv === 1'b1) begin
            q_a.push_back(a_tx_byte);
            busy_a = 3;
        end
        if (a_done === 1'b1) done_a++;
        if (a_err === 1'b1) err_a++;
    end

    // Transmitter model B: same behaviour for the masked instance.
    always @(negedge clk) begin
        b_tx_done = 1'b0;
        if (busy_b > 0) begin
            busy_b--;
            if (busy_b == 0) b_tx_done = 1'b1;
        end
        if (b_tx_dv === 1'b1) begin
            q_b.push_back(b_tx_byte);
            busy_b = 3;
        end
        if (b_done === 1'b1) done_b++;
        if (b_err === 1'b1) err_b++;
    end

    // Snapshot of the logs at the start of each directed step.
    int qa0, qb0, da0, db0, ea0, eb0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        qa0 = q_a.size();
        qb0 = q_b.size();
        da0 = done_a;
        db0 = done_b;
        ea0 = err_a;
        eb0 = err_b;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle receive strobe; returns on the falling edge after it was sampled.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send_byte(b);
        wait_cycles(2);
    endtask

    // Compare bytes transmitted since mark() against up to four expected bytes.
    task automatic check_tx(input string tag, input int n,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({tag, " a tx count"}, 32'(q_a.size() - qa0), 32'(n));
        check({tag, " b tx count"}, 32'(q_b.size() - qb0), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (qa0 + i < q_a.size())
                check($sformatf("%s a byte%0d", tag, i), 32'(q_a[qa0 + i]), 32'(e[i]));
            if (qb0 + i < q_b.size())
                check($sformatf("%s b byte%0d", tag, i), 32'(q_b[qb0 + i]), 32'(e[i] ^ MASK_B));
        end
    endtask

    task automatic check_pulses(input string tag, input int nd, input int ne);
        check({tag, " a done"}, 32'(done_a - da0), 32'(nd));
        check({tag, " b done"}, 32'(done_b - db0), 32'(nd));
        check({tag, " a err"},  32'(err_a - ea0),  32'(ne));
        check({tag, " b err"},  32'(err_b - eb0),  32'(ne));
    endtask

    initial begin
        // Reset values.
        wait_cycles(3);
        check("rst tx_dv",    32'(a_tx_dv),    32'd0);
        check("rst tx_byte",  32'(a_tx_byte),  32'h00);
        check("rst in_frame", 32'(a_in_frame), 32'd0);
        check("rst done",     32'(a_done),     32'd0);
        check("rst err",      32'(a_err),      32'd0);
        check("rst ovf",      32'(a_ovf),      32'd0);
        check("rst level",    32'(a_level),    32'd0);
        check("rst b level",  32'(b_level),    32'd0);
        rst = 1'b0;
        wait_cycles(2);

        // Basic frame AA,03,41,42,43 plus one-cycle push-to-request latency.
        mark();
        send_gap(8'hAA);
        check("basic in_frame after header", 32'(a_in_frame), 32'd1);
        send_gap(8'h03);
        send_byte(8'h41);
        check("latency level after push", 32'(a_level), 32'd1);
        check("latency no tx yet",        32'(a_tx_dv), 32'd0);
        wait_cycles(1);
        check("latency tx_dv",   32'(a_tx_dv),   32'd1);
        check("latency tx_byte", 32'(a_tx_byte), 32'h41);
        check("latency b byte",  32'(b_tx_byte), 32'h61);
        check("latency level after pop", 32'(a_level), 32'd0);
        send_gap(8'h42);
        send_gap(8'h43);
        wait_cycles(30);
        check_tx("basic", 3, 8'h41, 8'h42, 8'h43, 8'h00);
        check_pulses("basic", 1, 0);
        check("basic in_frame end", 32'(a_in_frame), 32'd0);
        check("basic tx_byte hold", 32'(a_tx_byte), 32'h43);

        // Header byte inside payload is data: AA,02,41,AA.
        mark();
        send_gap(8'hAA);
        send_gap(8'h02);
        send_gap(8'h41);
        send_gap(8'hAA);
        wait_cycles(30);
        check_tx("hdr_in_payload", 2, 8'h41, 8'hAA, 8'h00, 8'h00);
        check_pulses("hdr_in_payload", 1, 0);

        // Junk byte, zero length, over-long length: 55,AA,00,AA,FF.
        mark();
        send_gap(8'h55);
        check("junk ignored in_frame", 32'(a_in_frame), 32'd0);
        send_gap(8'hAA);
        send_gap(8'h00);
        check("zero len in_frame", 32'(a_in_frame), 32'd0);
        check("zero len no err", 32'(err_a - ea0), 32'd0);
        send_gap(8'hAA);
        send_gap(8'hFF);
        wait_cycles(10);
        check_tx("len_err", 0, 8'h00, 8'h00, 8'h00, 8'h00);
        check_pulses("len_err", 0, 1);

        // Length boundary: 64 accepted (then times out), 65 rejected at once.
        mark();
        send_gap(8'hAA);
        send_gap(8'h40);
        check("len64 in_frame", 32'(a_in_frame), 32'd1);
        check("len64 no err",   32'(err_a - ea0), 32'd0);
        wait_cycles(50);
        check("len64 timeout in_frame", 32'(a_in_frame), 32'd0);
        send_byte(8'hAA);
        send_byte(8'h41);
        check("len65 in_frame", 32'(a_in_frame), 32'd0);
        wait_cycles(2);
        check_pulses("len_bound", 0, 2);

        // Timeout while waiting for the length byte.
        mark();
        send_byte(8'hAA);
        wait_cycles(30);
        check("wait_len in_frame before timeout", 32'(a_in_frame), 32'd1);
        wait_cycles(20);
        check("wait_len in_frame after timeout", 32'(a_in_frame), 32'd0);
        check_pulses("wait_len timeout", 0, 1);

        // FIFO overflow with the transmitter held busy: AA,06,01..06.
        mark();
        tx_active = 1'b1;
        send_gap(8'hAA);
        send_gap(8'h06);
        for (int i = 1; i <= 6; i++) send_gap(8'(i));
        wait_cycles(5);
        check("ovf level",   32'(a_level), 32'd4);
        check("ovf count a", 32'(a_ovf),   32'd2);
        check("ovf count b", 32'(b_ovf),   32'd2);
        check_tx("ovf held", 0, 8'h00, 8'h00, 8'h00, 8'h00);
        tx_active = 1'b0;
        wait_cycles(60);
        check_tx("ovf drain", 4, 8'h01, 8'h02, 8'h03, 8'h04);
        check_pulses("ovf", 1, 0);
        check("ovf drained level", 32'(a_level), 32'd0);

        // Payload timeout; idle counter restarts on each received byte.
        mark();
        send_gap(8'hAA);
        send_byte(8'h05);
        wait_cycles(30);
        send_byte(8'h11);
        wait_cycles(30);
        check("timeout in_frame before", 32'(a_in_frame), 32'd1);
        check("timeout no err before", 32'(err_a - ea0), 32'd0);
        wait_cycles(20);
        check("timeout in_frame after", 32'(a_in_frame), 32'd0);
        check_tx("timeout", 1, 8'h11, 8'h00, 8'h00, 8'h00);
        check_pulses("timeout", 0, 1);

        // Reset mid-frame and mid-transmit: AA,04,01 then reset.
        send_gap(8'hAA);
        send_gap(8'h04);
        send_byte(8'h01);
        wait_cycles(2);
        check("pre-reset tx_byte", 32'(a_tx_byte), 32'h01);
        rst = 1'b1;
        wait_cycles(2);
        check("mid rst tx_dv",    32'(a_tx_dv),    32'd0);
        check("mid rst tx_byte",  32'(a_tx_byte),  32'h00);
        check("mid rst in_frame", 32'(a_in_frame), 32'd0);
        check("mid rst done",     32'(a_done),     32'd0);
        check("mid rst err",      32'(a_err),      32'd0);
        check("mid rst ovf",      32'(a_ovf),      32'd0);
        check("mid rst level",    32'(a_level),    32'd0);
        rst = 1'b0;
        wait_cycles(4);
        mark();
        send_gap(8'h02);
        wait_cycles(20);
        check_tx("post rst", 0, 8'h00, 8'h00, 8'h00, 8'h00);
        check("post rst in_frame", 32'(a_in_frame), 32'd0);
        check("post rst level",    32'(a_level),    32'd0);
        mark();
        send_gap(8'hAA);
        send_gap(8'h01);
        send_gap(8'h7E);
        wait_cycles(20);
        check_tx("fresh frame", 1, 8'h7E, 8'h00, 8'h00, 8'h00);
        check_pulses("fresh frame", 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_framed_echo.md
UART_FRAMED_ECHO -- requirements
Module: uart_framed_echo

Interface
REQ-001 SHALL have parameter HEADER_BYTE, default 8'hAA, the frame start marker.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, payload buffer entries; power of two, 2..256.
REQ-003 SHALL have parameter MAX_LEN, default 64, the largest legal payload length, 1..255.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 250_000, idle clocks allowed between bytes inside a frame; must be >= 1.
REQ-005 SHALL have parameter XOR_MASK, default 8'h00, applied to every echoed payload byte.
REQ-006 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port i_rx_dv, input, 1, one-cycle strobe marking a received byte.
REQ-009 SHALL have port i_rx_byte, input, 8, the received byte; valid when i_rx_dv=1.
REQ-010 SHALL have port i_tx_active, input, 1, high while the UART transmitter is busy.
REQ-011 SHALL have port i_tx_done, input, 1, one-cycle strobe at the end of a transmitted byte.
REQ-012 SHALL have port o_tx_dv, output, 1, one-cycle transmit request.
REQ-013 SHALL have port o_tx_byte, output, 8, the byte to transmit; valid when o_tx_dv=1.
REQ-014 SHALL have port o_in_frame, output, 1, high in WAIT_LEN or PAYLOAD.
REQ-015 SHALL have port o_frame_done, output, 1, one-cycle pulse when the last payload byte is accepted.
REQ-016 SHALL have port o_frame_err, output, 1, one-cycle pulse on a length error or timeout.
REQ-017 SHALL have port o_overflow_cnt, output, 8, count of payload bytes dropped because the FIFO was full; saturates at 255.
REQ-018 SHALL have port o_fifo_level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-019 SHALL implement the states WAIT_HEADER, WAIT_LEN and PAYLOAD.
REQ-020 In WAIT_HEADER, rx_dv with byte==HEADER_BYTE SHALL go to WAIT_LEN; any other byte SHALL be ignored.
REQ-021 In WAIT_LEN, rx_dv with len of 0 SHALL return to WAIT_HEADER with no pulse.
REQ-022 In WAIT_LEN, rx_dv with len > MAX_LEN SHALL return to WAIT_HEADER and pulse o_frame_err.
REQ-023 In WAIT_LEN, any other len SHALL load a remaining counter with len and go to PAYLOAD.
REQ-024 In PAYLOAD, each rx_dv SHALL push (rx_byte XOR XOR_MASK) into the FIFO and decrement remaining.
REQ-025 When remaining reaches 0, the FSM SHALL pulse o_frame_done in the cycle after the last byte and go to WAIT_HEADER.
REQ-026 HEADER_BYTE received inside PAYLOAD SHALL be treated as ordinary data.
REQ-027 If the FIFO is full during a push, the byte SHALL be dropped, o_overflow_cnt SHALL increment (saturating), and frame counting SHALL still advance.
REQ-028 An idle counter SHALL clear on every rx_dv and on entry to WAIT_LEN.
REQ-029 Reaching TIMEOUT_CYCLES in WAIT_LEN or PAYLOAD SHALL return the FSM to WAIT_HEADER and pulse o_frame_err; FIFO contents already accepted SHALL still be transmitted.
REQ-030 An internal tx_busy flag SHALL be set when o_tx_dv is asserted and cleared on i_tx_done.
REQ-031 When the FIFO is non-empty, tx_busy=0 and i_tx_active=0, the block SHALL assert o_tx_dv for exactly one cycle with o_tx_byte=FIFO head and pop in the same cycle.
REQ-032 o_tx_byte SHALL hold its value until the next o_tx_dv.
REQ-033 A push and a pop in the same cycle SHALL leave o_fifo_level unchanged.
REQ-034 A push to a full FIFO in a cycle with a pop SHALL succeed and SHALL NOT count as overflow.
REQ-035 Bytes SHALL be transmitted in arrival order; latency from a push into an empty idle FIFO to o_tx_dv SHALL be 1 cycle.
REQ-036 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-037 While i_rst=1 at a clock edge, the block SHALL set state=WAIT_HEADER, empty the FIFO, clear tx_busy and the idle and remaining counters, and force o_tx_dv=0, o_tx_byte=8'h00, o_frame_done=0, o_frame_err=0, o_in_frame=0, o_overflow_cnt=0, o_fifo_level=0.
REQ-038 Reset asserted mid-frame or mid-transmit SHALL discard all state; the next frame SHALL require a fresh HEADER_BYTE.

Verification
REQ-039 Rx AA,03,41,42,43 with the TX idle -> three o_tx_dv with 41,42,43 in order, one o_frame_done, o_frame_err never asserted.
REQ-040 With XOR_MASK=8'h20, rx AA,02,41,AA -> tx 61,8A.
REQ-041 Rx 55,AA,00,AA,FF (MAX_LEN=64) -> no tx; the 00 returns the FSM to WAIT_HEADER silently; FF pulses o_frame_err once.
REQ-042 FIFO_DEPTH=4 with i_tx_active held high, rx AA,06 then 6 bytes -> o_fifo_level=4, o_overflow_cnt=2, o_frame_done pulsed; releasing i_tx_active -> exactly 4 bytes transmitted.
REQ-043 Rx AA,05,11 then silence for TIMEOUT_CYCLES -> o_frame_err pulse, o_in_frame=0, 11 still echoed.
REQ-044 Assert i_rst after AA,04,01 -> all outputs reach their reset values; a following rx of 02 produces no tx.
